// File: rtl/keypad_scanner.sv
//------------------------------------------------------------------------------
// Module   : keypad_scanner
// Function : 4x4 matrix keypad column scanner with press/release debouncing.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_in,
    output logic [3:0] col_drive,
    output logic [3:0] r,
    output logic [3:0] c,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBC_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0] DBC_TOP  = DBC_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       cand_row_q, cand_row_d;
    logic [3:0]       cand_col_q, cand_col_d;
    logic [3:0]       r_q, r_d;
    logic [3:0]       c_q, c_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic [3:0]       rows;
    logic             rows_onehot;
    logic [DBC_W-1:0] dbc_inc;

    assign rows        = sync2_q;
    assign rows_onehot = (rows != 4'b0000) && ((rows & (rows - 4'b0001)) == 4'b0000);
    assign dbc_inc     = dbc_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sync1_d     = rows_in;
        sync2_d     = sync1_q;
        div_d       = div_q;
        dbc_d       = dbc_q;
        col_d       = col_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        r_d         = r_q;
        c_d         = c_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (rows_onehot) begin
                        cand_row_d = rows;
                        cand_col_d = col_q;
                        dbc_d      = '0;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (rows == cand_row_q) begin
                    if (dbc_inc == DBC_TOP) begin
                        r_d         = cand_row_q;
                        c_d         = cand_col_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        dbc_d       = '0;
                        state_d     = ST_HELD;
                    end else begin
                        dbc_d = dbc_inc;
                    end
                end else begin
                    dbc_d   = '0;
                    div_d   = '0;
                    state_d = ST_SCAN;
                end
            end

            // Only the accepted row is watched; other keys cannot disturb a held press.
            ST_HELD: begin
                if ((rows & cand_row_q) == 4'b0000) begin
                    dbc_d   = DBC_W'(1);
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if ((rows & cand_row_q) != 4'b0000) begin
                    dbc_d   = '0;
                    state_d = ST_HELD;
                end else if ((dbc_inc == DBC_TOP) || (dbc_q >= DBC_TOP)) begin
                    key_held_d = 1'b0;
                    dbc_d      = '0;
                    div_d      = '0;
                    state_d    = ST_SCAN;
                end else begin
                    dbc_d = dbc_inc;
                end
            end

            default: begin
                state_d = ST_SCAN;
                div_d   = '0;
                dbc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            sync1_q     <= 4'b0000;
            sync2_q     <= 4'b0000;
            div_q       <= '0;
            dbc_q       <= '0;
            col_q       <= 4'b0001;
            cand_row_q  <= 4'b0000;
            cand_col_q  <= 4'b0000;
            r_q         <= 4'b0000;
            c_q         <= 4'b0000;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            div_q       <= div_d;
            dbc_q       <= dbc_d;
            col_q       <= col_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            r_q         <= r_d;
            c_q         <= c_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_drive = col_q;
    assign r         = r_q;
    assign c         = c_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad columns one-hot and samples the four row lines.
- Debounces a single key press and emits the one-hot row/column pair consumed by the keypad decoder, plus a one-cycle new-key strobe.
- Sits between the keypad pins and the decoder.
- Guarantees one strobe per physical press, with bounce and multi-key noise rejected.

Parameters:
- SCAN_DIV, 1000: clock cycles each column stays driven before advancing; must be >= 2.
- DEBOUNCE_CNT, 50000: consecutive stable cycles required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rows_in  input  4  raw asynchronous keypad row lines; active-high, pulled down externally.
- col_drive  output  4  one-hot column drive to the keypad; active-high.
- r  output  4  one-hot row of the accepted key; 0 when no key has been accepted since reset.
- c  output  4  one-hot column of the accepted key; 0 when no key has been accepted since reset.
- key_valid  output  1  single-cycle pulse when a new debounced press is accepted.
- key_held  output  1  high while the accepted key is considered pressed.

Behaviour:
- rows_in passes through a 2-flop synchronizer; "rows" below means the synchronized value. All logic is on the clk rising edge.
- Reset (synchronous, takes priority over everything):
  - col_drive=4'b0001; r=0, c=0; key_valid=0; key_held=0.
  - state=SCAN; divider and debounce counters = 0; synchronizer flops = 0.
  - Reset mid-press aborts without a key_valid pulse.
- Divider:
  - Counts 0..SCAN_DIV-1 in SCAN only; "tick" = count==SCAN_DIV-1.
  - Cleared on every entry to SCAN.
- SCAN:
  - On tick, if rows is one-hot: latch cand_row=rows and cand_col=col_drive, go to DEBOUNCE, and hold col_drive. The column does not advance.
  - On tick, if rows is zero or has more than one bit set: rotate col_drive left (0001->0010->0100->1000->0001) and stay in SCAN.
  - Between ticks: hold col_drive and ignore rows.
- DEBOUNCE (col_drive frozen):
  - Each cycle with rows==cand_row increments dbc.
  - Any cycle with rows!=cand_row clears dbc and returns to SCAN. The column advances on the next tick as usual.
  - When the increment makes dbc==DEBOUNCE_CNT: on that same edge r<=cand_row, c<=cand_col, key_valid<=1, key_held<=1, dbc<=0, state<=HELD.
  - Press latency: key_valid is high exactly DEBOUNCE_CNT+1 cycles after the detecting tick cycle, given stable input.
- HELD:
  - key_valid forced to 0 (pulse is exactly one cycle).
  - key_held=1; col_drive frozen.
  - Only rows bit cand_row is monitored. Other rows in the same column, and keys in undriven columns, are ignored.
  - If the cand_row bit is 0: dbc<=1, go to RELEASE.
- RELEASE:
  - Cand_row bit 1: dbc<=0, back to HELD. No new key_valid is generated.
  - Cand_row bit 0: dbc increments.
  - When dbc reaches DEBOUNCE_CNT: key_held<=0, dbc<=0, state<=SCAN.
  - r and c keep the last accepted key until the next accept.
- Same key pressed again after a completed release: a new key_valid pulse is generated.
- Widths: dbc is $clog2(DEBOUNCE_CNT+1) bits and the divider is $clog2(SCAN_DIV) bits. Neither counter wraps; both are cleared on state change.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
1. Reset, no keys -> col_drive cycles 0001,0010,0100,1000,0001 with 4 cycles each; r=c=0; key_valid and key_held stay 0.
2. Hold rows_in=0100 only while col_drive=0010, stable -> col_drive freezes at 0010; key_valid pulses 1 cycle exactly 9 cycles after the detecting tick; r=0100, c=0010; key_held=1.
3. Bouncing press: toggle rows_in every 3 cycles for 30 cycles, then hold stable -> no key_valid during bounce; exactly one pulse after the final 8 stable cycles.
4. Release bounce: in HELD, drop the row for 5 cycles, restore it for 2, then drop permanently -> no second key_valid; key_held falls 8 cycles after the permanent drop; scanning resumes.
5. Two rows asserted (0011) in one column -> no capture; col_drive keeps rotating.
6. Assert reset for 1 cycle in the middle of DEBOUNCE -> next cycle col_drive=0001, r=c=0, key_held=0; no key_valid pulse.
